// File: rtl/uart_tx_sequencer.sv
// Wishbone master that programs uart_interface and sends a 32-bit result as 1-4 bytes, LSB first.
// Every access is preceded by one idle bus cycle; ack timeout, bus error and poll overrun end in ERR.
module uart_tx_sequencer #(
  parameter logic [31:0] BAUD_ADDR   = 32'h4,
  parameter logic [31:0] CTRL_ADDR   = 32'h3,
  parameter logic [31:0] TXBUF_ADDR  = 32'h7,
  parameter logic [31:0] FLAG_ADDR   = 32'h5,
  parameter logic [31:0] CTRL_RESET  = 32'h68,
  parameter logic [31:0] CTRL_START  = 32'hE0,
  parameter int          DONE_BIT    = 0,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          POLL_LIMIT  = 65535
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        send_i,
  input  logic [31:0] payload_i,
  input  logic [2:0]  len_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  input  logic        m_err_i
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT);

  typedef enum logic [3:0] {
    S_IDLE, S_BAUD, S_TXRST, S_LOAD, S_START, S_POLL, S_CLEAR, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    last_idx_q, last_idx_d;
  logic [31:0]   payload_q, payload_d;
  logic [31:0]   divisor_q, divisor_d;

  logic [31:0]   acc_adr;
  logic [31:0]   acc_dat;
  logic          acc_we;
  logic [3:0]    acc_sel;
  state_t        next_ok;
  logic [PW-1:0] poll_inc;
  logic          unused_rdata;

  assign unused_rdata = ^m_dat_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cyc_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      to_cnt_q   <= '0;
      poll_cnt_q <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      payload_q  <= '0;
      divisor_q  <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      to_cnt_q   <= to_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      payload_q  <= payload_d;
      divisor_q  <= divisor_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    sel_d      = sel_q;
    to_cnt_d   = to_cnt_q;
    poll_cnt_d = poll_cnt_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    payload_d  = payload_q;
    divisor_d  = divisor_q;
    acc_adr    = '0;
    acc_dat    = '0;
    acc_we     = 1'b1;
    acc_sel    = 4'hF;
    next_ok    = state_q;
    poll_inc   = poll_cnt_q + 1'b1;

    // What each access state puts on the bus, and where it goes once acked
    case (state_q)
      S_BAUD:  begin acc_adr = BAUD_ADDR;  acc_dat = divisor_q;  next_ok = S_TXRST; end
      S_TXRST: begin acc_adr = CTRL_ADDR;  acc_dat = CTRL_RESET; next_ok = S_LOAD;  end
      S_LOAD: begin
        acc_adr = TXBUF_ADDR;
        acc_dat = payload_q;
        acc_sel = 4'b0001 << idx_q;
        next_ok = S_START;
      end
      S_START: begin acc_adr = CTRL_ADDR;  acc_dat = CTRL_START; next_ok = S_POLL;  end
      S_POLL: begin
        acc_adr = CTRL_ADDR;
        acc_we  = 1'b0;
        if (m_dat_i[DONE_BIT])       next_ok = S_CLEAR;
        else if (poll_inc == POLL_LAST) next_ok = S_ERR;
        else                          next_ok = S_POLL;
      end
      S_CLEAR: begin
        acc_adr = FLAG_ADDR;
        next_ok = (idx_q == last_idx_q) ? S_DONE : S_LOAD;
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (send_i) begin
          payload_d  = payload_i;
          divisor_d  = divisor_i;
          idx_d      = '0;
          poll_cnt_d = '0;
          case (len_i)
            3'd1:    last_idx_d = 2'd0;
            3'd2:    last_idx_d = 2'd1;
            3'd3:    last_idx_d = 2'd2;
            default: last_idx_d = 2'd3;
          endcase
          state_d = S_BAUD;
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default: begin
        if (!cyc_q) begin
          cyc_d    = 1'b1;
          adr_d    = acc_adr;
          dat_d    = acc_dat;
          we_d     = acc_we;
          sel_d    = acc_sel;
          to_cnt_d = '0;
        end else if (m_err_i || m_ack_i || to_cnt_q == TO_LAST) begin
          cyc_d = 1'b0;
          adr_d = '0;
          dat_d = '0;
          we_d  = 1'b0;
          sel_d = '0;
          if (m_ack_i && !m_err_i) begin
            state_d = next_ok;
            if (state_q == S_START) poll_cnt_d = '0;
            if (state_q == S_POLL && !m_dat_i[DONE_BIT]) poll_cnt_d = poll_inc;
            if (state_q == S_CLEAR && idx_q != last_idx_q) idx_d = idx_q + 2'd1;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_DONE);
  assign fail_o  = (state_q == S_ERR);
  assign m_adr_o = adr_q;
  assign m_dat_o = dat_q;
  assign m_we_o  = we_q;
  assign m_sel_o = sel_q;
  assign m_cyc_o = cyc_q;
  assign m_stb_o = cyc_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: model slave, expected-access queue built from the transfer rules,
// and a per-cycle compare process on the falling edge.
module tb_uart_tx_sequencer;

  localparam int POLL_LIM = 8;
  localparam int ACK_TO   = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        send_i = 1'b0;
  logic [31:0] payload_i = '0;
  logic [2:0]  len_i = '0;
  logic [31:0] divisor_i = '0;
  logic        busy_o, done_o, fail_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [31:0] m_dat_i = '0;
  logic        m_we_o;
  logic [3:0]  m_sel_o;
  logic        m_cyc_o, m_stb_o;
  logic        m_ack_i = 1'b0;
  logic        m_err_i = 1'b0;

  always #5 clk_i = ~clk_i;

  uart_tx_sequencer #(.ACK_TIMEOUT(ACK_TO), .POLL_LIMIT(POLL_LIM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .send_i(send_i), .payload_i(payload_i),
    .len_i(len_i), .divisor_i(divisor_i), .busy_o(busy_o), .done_o(done_o),
    .fail_o(fail_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    logic        chk;
  } acc_t;

  acc_t        exp_q[$];
  acc_t        cur;
  int          checks = 0, failures = 0;
  int          seen_cnt = 0, done_cnt = 0, fail_cnt = 0, read_cnt = 0, byte_cnt = 0;
  int          run = 0, last_run = 0;
  logic [31:0] bytes_got = '0, last_adr = '0;
  logic [31:0] prev_adr = '0, prev_dat = '0;
  logic [4:0]  prev_ctl = '0;
  bit          prev_valid = 0, in_xfer = 0;
  bit          withhold_txbuf = 0, err_baud = 0;
  int          polls_to_done = 3, ack_delay = 0, slave_polls = 0, wait_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic void pushAcc(input logic [31:0] a, input logic [31:0] d, input logic w,
                                  input logic [3:0] s, input logic c);
    acc_t e;
    e.adr = a; e.dat = d; e.we = w; e.sel = s; e.chk = c;
    exp_q.push_back(e);
  endfunction

  // Reference transfer: the access list a complete transfer must produce, cut at the failure point
  function automatic void buildExpected(input logic [31:0] payload, input logic [2:0] len,
                                        input logic [31:0] divisor, input int polls, input int keep);
    int n = (len == 3'd0 || len > 3'd4) ? 4 : int'(len);
    int p = (polls == 0) ? POLL_LIM : polls;
    pushAcc(32'h4, divisor, 1'b1, 4'hF, 1'b1);
    pushAcc(32'h3, 32'h68, 1'b1, 4'hF, 1'b1);
    for (int b = 0; b < n; b++) begin
      pushAcc(32'h7, payload, 1'b1, 4'(1 << b), 1'b1);
      pushAcc(32'h3, 32'hE0, 1'b1, 4'hF, 1'b1);
      for (int k = 0; k < p; k++) pushAcc(32'h3, 32'h0, 1'b0, 4'hF, 1'b0);
      pushAcc(32'h5, 32'h0, 1'b1, 4'hF, 1'b1);
    end
    while (exp_q.size() > keep) void'(exp_q.pop_back());
  endfunction

  // Model slave: acks after ack_delay extra cycles, reports done on the Nth poll after START
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      m_ack_i = 1'b0;
      m_err_i = 1'b0;
      m_dat_i = '0;
      if (rst_ni && m_cyc_o && m_stb_o) begin
        wait_cnt++;
        if (!(withhold_txbuf && m_adr_o == 32'h7) && wait_cnt > ack_delay) begin
          wait_cnt = 0;
          if (err_baud && m_adr_o == 32'h4) m_err_i = 1'b1;
          else begin
            m_ack_i = 1'b1;
            if (m_we_o && m_adr_o == 32'h3 && m_dat_o == 32'hE0) slave_polls = 0;
            if (!m_we_o && m_adr_o == 32'h3) begin
              slave_polls++;
              m_dat_i = ($urandom & 32'hFFFF_FFFE) |
                        ((polls_to_done != 0 && slave_polls >= polls_to_done) ? 32'h1 : 32'h0);
            end
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Compare process: protocol stability, busy, and each terminated access against the queue
  initial begin
    int lane;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_valid = 0;
        run = 0;
        continue;
      end
      if (in_xfer) checkOutput("busy_during_xfer", 32'(busy_o), 32'h1);
      if (m_cyc_o) begin
        checkOutput("stb_with_cyc", 32'(m_stb_o), 32'h1);
        run++;
        last_adr = m_adr_o;
        if (prev_valid) begin
          checkOutput("hold_adr", m_adr_o, prev_adr);
          checkOutput("hold_dat", m_dat_o, prev_dat);
          checkOutput("hold_we_sel", 32'({m_we_o, m_sel_o}), 32'(prev_ctl));
        end
        if (m_ack_i || m_err_i) begin
          seen_cnt++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_access_adr", m_adr_o, 32'hFFFF_FFFF);
          end else begin
            cur = exp_q.pop_front();
            checkOutput("access_adr", m_adr_o, cur.adr);
            checkOutput("access_we_sel", 32'({m_we_o, m_sel_o}), 32'({cur.we, cur.sel}));
            if (cur.chk) checkOutput("access_dat", m_dat_o, cur.dat);
          end
          if (!m_we_o) read_cnt++;
          if (m_we_o && m_adr_o == 32'h7 && byte_cnt < 4) begin
            lane = 0;
            for (int k = 0; k < 4; k++) if (m_sel_o[k]) lane = k;
            bytes_got[8*byte_cnt +: 8] = m_dat_o[8*lane +: 8];
            byte_cnt++;
          end
          prev_valid = 0;
        end else begin
          prev_valid = 1;
          prev_adr = m_adr_o;
          prev_dat = m_dat_o;
          prev_ctl = {m_we_o, m_sel_o};
        end
      end else begin
        checkOutput("stb_idle", 32'(m_stb_o), 32'h0);
        if (run != 0) last_run = run;
        run = 0;
        prev_valid = 0;
      end
      if (done_o) begin done_cnt++; in_xfer = 0; end
      if (fail_o) begin fail_cnt++; in_xfer = 0; end
    end
  end

  task automatic applyStimulus(input logic [31:0] payload, input logic [2:0] len,
                               input logic [31:0] divisor, input int polls, input bit withhold,
                               input bit err, input bit intrude, input int delay);
    int  waited;
    int  keep;
    bit  success;
    withhold_txbuf = withhold;
    err_baud = err;
    polls_to_done = polls;
    ack_delay = delay;
    keep = err ? 1 : withhold ? 2 : (polls == 0) ? 4 + POLL_LIM : 1000;
    success = !withhold && !err && polls != 0;
    exp_q.delete();
    buildExpected(payload, len, divisor, polls, keep);
    seen_cnt = 0; done_cnt = 0; fail_cnt = 0; read_cnt = 0; byte_cnt = 0;
    bytes_got = '0; last_run = 0;
    @(negedge clk_i);
    payload_i = payload; len_i = len; divisor_i = divisor; send_i = 1'b1;
    @(negedge clk_i);
    send_i = 1'b0;
    in_xfer = 1;
    if (intrude) begin
      repeat (2) @(negedge clk_i);
      payload_i = ~payload; divisor_i = ~divisor; len_i = 3'd1; send_i = 1'b1;
      @(negedge clk_i);
      send_i = 1'b0;
    end
    waited = 0;
    while (done_cnt + fail_cnt == 0 && waited < 3000) begin
      @(negedge clk_i);
      #1;
      waited++;
    end
    checkOutput("completion_within_bound", 32'(waited < 3000), 32'h1);
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("busy_after_end", 32'(busy_o), 32'h0);
    checkOutput("cyc_after_end", 32'(m_cyc_o), 32'h0);
    checkOutput("done_pulses", 32'(done_cnt), 32'(success));
    checkOutput("fail_pulses", 32'(fail_cnt), 32'(!success));
    checkOutput("missing_accesses", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int  waited;
    int  nb;
    logic [31:0] rp, rd;
    logic [2:0]  rl;
    #12;
    checkOutput("reset_busy", 32'(busy_o), 32'h0);
    checkOutput("reset_done", 32'(done_o), 32'h0);
    checkOutput("reset_fail", 32'(fail_o), 32'h0);
    checkOutput("reset_cyc_stb", 32'({m_cyc_o, m_stb_o}), 32'h0);
    checkOutput("reset_we_sel", 32'({m_we_o, m_sel_o}), 32'h0);
    checkOutput("reset_adr", m_adr_o, 32'h0);
    checkOutput("reset_dat", m_dat_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    applyStimulus(32'h61626364, 3'd4, 32'h40000000, 3, 0, 0, 0, 0);
    checkOutput("t1_accesses", 32'(seen_cnt), 32'd26);
    checkOutput("t1_bytes", bytes_got, 32'h61626364);
    checkOutput("t1_reads", 32'(read_cnt), 32'd12);

    applyStimulus(32'hAABBCC55, 3'd1, 32'h00000010, 3, 0, 0, 0, 0);
    checkOutput("len1_accesses", 32'(seen_cnt), 32'd8);
    checkOutput("len1_bytes", bytes_got, 32'h00000055);

    applyStimulus(32'h0BADF00D, 3'd0, 32'h00000020, 2, 0, 0, 0, 1);
    checkOutput("len0_accesses", 32'(seen_cnt), 32'd22);
    checkOutput("len0_bytes", bytes_got, 32'h0BADF00D);

    applyStimulus(32'h11223344, 3'd2, 32'h00000030, 3, 1, 0, 0, 0);
    checkOutput("timeout_accesses", 32'(seen_cnt), 32'd2);
    checkOutput("timeout_stb_cycles", 32'(last_run), 32'd16);
    checkOutput("timeout_last_adr", last_adr, 32'h7);

    applyStimulus(32'h55667788, 3'd3, 32'h00000040, 3, 0, 1, 0, 0);
    checkOutput("err_accesses", 32'(seen_cnt), 32'd1);

    applyStimulus(32'h12345678, 3'd4, 32'h00000050, 0, 0, 0, 1, 0);
    checkOutput("polllim_accesses", 32'(seen_cnt), 32'd12);
    checkOutput("polllim_reads", 32'(read_cnt), 32'd8);
    checkOutput("polllim_byte", bytes_got, 32'h00000078);

    // Reset in the middle of a status read must drop the bus without a clock edge
    withhold_txbuf = 0; err_baud = 0; polls_to_done = 0; ack_delay = 0;
    exp_q.delete();
    buildExpected(32'hCAFEBABE, 3'd4, 32'h00000060, 0, 4 + POLL_LIM);
    @(negedge clk_i);
    payload_i = 32'hCAFEBABE; len_i = 3'd4; divisor_i = 32'h60; send_i = 1'b1;
    @(negedge clk_i);
    send_i = 1'b0;
    in_xfer = 1;
    waited = 0;
    while (!(m_cyc_o && !m_we_o) && waited < 200) begin
      @(posedge clk_i);
      #1;
      waited++;
    end
    checkOutput("reached_poll", 32'(waited < 200), 32'h1);
    #1;
    in_xfer = 0;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_mid_cyc_stb", 32'({m_cyc_o, m_stb_o}), 32'h0);
    checkOutput("rst_mid_busy", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    exp_q.delete();
    applyStimulus(32'hDEADBEEF, 3'd2, 32'h00000070, 2, 0, 0, 0, 0);
    checkOutput("after_rst_bytes", bytes_got, 32'h0000BEEF);

    for (int r = 0; r < 6; r++) begin
      rp = $urandom;
      rd = $urandom;
      rl = 3'($urandom_range(0, 7));
      applyStimulus(rp, rl, rd, $urandom_range(1, 4), 0, 0, 0, $urandom_range(0, 3));
      nb = (rl == 3'd0 || rl > 3'd4) ? 4 : int'(rl);
      checkOutput("rand_byte_count", 32'(byte_cnt), 32'(nb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
